moore_seq_scheduler: RTL and testbench
======================================

# moore_seq_scheduler

Round-robin scheduler sharing one serial Moore detector (single-bit `input_signal` in, single-bit `output_signal` out) among several requesters. Each requester submits a fixed-width bit frame. The scheduler grants one requester, clears the detector, shifts the frame in MSB-first, drains the detector pipeline, counts the detector's high outputs and reports the result tagged with the requester id. It sits between the requester blocks and the detector instance and is the only driver of the detector's reset and input.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (≥2)
- `FRAME_W`, 8, bits per frame (≥2)
- `FLUSH_CYCLES`, 1, drain cycles after the last bit (≥1)
- derived `ID_W` = $clog2(NUM_REQ); `CNT_W` = $clog2(FRAME_W+FLUSH_CYCLES)

Ports:
- `clk`  in  1  single clock, rising edge
- `resetn`  in  1  asynchronous, active-low reset
- `req`  in  NUM_REQ  per-requester request level; held with data until granted
- `frame_data`  in  NUM_REQ*FRAME_W  requester i frame at [i*FRAME_W +: FRAME_W]
- `grant`  out  NUM_REQ  one-hot, one-cycle accept pulse
- `busy`  out  1  high in every state except IDLE
- `fsm_resetn`  out  1  to detector `resetn`; low except in SHIFT/DRAIN
- `fsm_in`  out  1  to detector `input_signal`
- `fsm_out`  in  1  from detector `output_signal`
- `done`  out  1  one-cycle result strobe
- `done_id`  out  ID_W  requester served; held until next `done`
- `hit_count`  out  CNT_W+1  number of high `fsm_out` samples; held until next `done`

## Operation
- States: IDLE → LOAD → SHIFT → DRAIN → REPORT → IDLE.
- IDLE:
  - If any `req` bit is set, pick the winner round-robin, starting at `last_id+1` mod NUM_REQ.
  - Register the winner; go to LOAD.
  - `last_id` resets to NUM_REQ-1, so requester 0 has first priority.
- LOAD (1 cycle):
  - `grant[winner]`=1.
  - Capture the winner's `frame_data` into the shift register at the end of the cycle.
  - Update `last_id`=winner.
  - `fsm_resetn`=0.
- SHIFT (FRAME_W cycles):
  - `fsm_resetn`=1.
  - `fsm_in` = frame bit FRAME_W-1 in the first cycle, then descending to bit 0.
- DRAIN (FLUSH_CYCLES cycles): `fsm_resetn`=1, `fsm_in`=0.
- Sampling: `fsm_out` is sampled in every SHIFT cycle except the first, and in every DRAIN cycle. The hit counter increments on each high sample and clears in LOAD.
- REPORT (1 cycle): `done`=1; `done_id` and `hit_count` are updated on entry. Next state is always IDLE, so no request is considered in REPORT.
- Requester protocol:
  - A `req` dropped before its grant is simply not served.
  - A `req` still high after its grant is treated as a new request.
  - Simultaneous requests are resolved purely by round-robin order.
- Arithmetic: the counter saturates at its maximum value (unreachable with the derived width).

## Timing
- Reset (async assert, sync-free release) values:
  - state=IDLE, `grant`=0, `busy`=0, `fsm_resetn`=0, `fsm_in`=0
  - `done`=0, `done_id`=0, `hit_count`=0, `last_id`=NUM_REQ-1
- Per-request timing, with `req` high at edge 0:
  - LOAD occupies cycle 1.
  - SHIFT occupies cycles 2..FRAME_W+1.
  - DRAIN occupies the next FLUSH_CYCLES cycles.
  - REPORT occupies cycle FRAME_W+FLUSH_CYCLES+2.
  - Service period is FRAME_W+FLUSH_CYCLES+3 cycles including the IDLE.
- Reset asserted mid-frame:
  - All outputs return to reset values immediately, which also resets the detector.
  - The in-flight frame is dropped with no `done`.
  - Requesters must re-request.
- All outputs are registered; `fsm_resetn` and `fsm_in` must be glitch-free.

## Configuration
- `MOORE_SCHED_FIRST_HIT_EN` defined:
  - Adds outputs `first_hit_valid` (1) and `first_hit_pos` (CNT_W+1).
  - These give the 0-based sample index of the first high `fsm_out` sample in the frame.
  - They update in REPORT with `done` and reset to 0.
  - `first_hit_valid`=0 if `hit_count`=0.
- Not defined: the ports and logic are absent; all other behaviour is identical.

## Test plan
Detector stub for all scenarios: a flop with `fsm_out <= fsm_in`, reset by `fsm_resetn`.
- Reset values and single frame:
  - Check all outputs 0 and `fsm_resetn`=0 during reset.
  - `req`=4'b0001, frame0=8'hA5 → `grant`=0001 at cycle 1; `fsm_in` sequence 1,0,1,0,0,1,0,1 on cycles 2..9.
  - `done` at cycle 11 with `done_id`=0, `hit_count`=4.
- Round-robin: `req`=4'b1111 held → grant order 0,1,2,3,0, each `done` 12 cycles apart.
- Frame edge cases: frame 8'h00 → `hit_count`=0; frame 8'hFF → `hit_count`=8.
- Reset mid-frame: assert `resetn` at cycle 5 of a frame → outputs reset at once, no `done`; after re-request the frame completes normally with `done_id` restarting from requester 0 priority.
- Late request: `req` rises for requester 2 during SHIFT of requester 0 → served immediately after REPORT+IDLE, `done_id`=2.
- `MOORE_SCHED_FIRST_HIT_EN`: frame 8'h10 → `first_hit_valid`=1, `first_hit_pos`=3, `hit_count`=1; frame 8'h00 → `first_hit_valid`=0.

Source files
------------

// File: rtl/moore_seq_scheduler_if.sv
// Requester-side bus of the Moore detector scheduler.
// Optional MOORE_SCHED_FIRST_HIT_EN adds the first-hit report signals.
interface moore_seq_scheduler_if #(
    parameter int NUM_REQ      = 4,
    parameter int FRAME_W      = 8,
    parameter int FLUSH_CYCLES = 1
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(FRAME_W + FLUSH_CYCLES);

    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ*FRAME_W-1:0] frame_data;
    logic [NUM_REQ-1:0]         grant;
    logic                       busy;
    logic                       done;
    logic [ID_W-1:0]            done_id;
    logic [CNT_W:0]             hit_count;
`ifdef MOORE_SCHED_FIRST_HIT_EN
    logic                       first_hit_valid;
    logic [CNT_W:0]             first_hit_pos;
`endif

    modport slave (
`ifdef MOORE_SCHED_FIRST_HIT_EN
        output first_hit_valid, first_hit_pos,
`endif
        input  req, frame_data,
        output grant, busy, done, done_id, hit_count
    );

    modport master (
`ifdef MOORE_SCHED_FIRST_HIT_EN
        input  first_hit_valid, first_hit_pos,
`endif
        output req, frame_data,
        input  grant, busy, done, done_id, hit_count
    );
endinterface

// File: rtl/moore_seq_scheduler.sv
// Round-robin scheduler time-sharing one serial Moore detector among requesters.
// Optional MOORE_SCHED_FIRST_HIT_EN reports the index of the first high sample.
module moore_seq_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int FRAME_W      = 8,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    moore_seq_scheduler_if.slave  bus,
    output logic                  fsm_resetn,
    output logic                  fsm_in,
    input  logic                  fsm_out
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(FRAME_W + FLUSH_CYCLES);

    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [ID_W-1:0]  LAST_RST   = ID_W'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SHIFT, S_DRAIN, S_REPORT
    } state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    win_q, win_d;
    logic [ID_W-1:0]    last_q, last_d;
    logic [FRAME_W-1:0] sr_q, sr_d;
    logic [CNT_W-1:0]   step_q, step_d;
    logic [CNT_W:0]     cnt_q, cnt_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               busy_q, busy_d;
    logic               fsm_resetn_q, fsm_resetn_d;
    logic               fsm_in_q, fsm_in_d;
    logic               done_q, done_d;
    logic [ID_W-1:0]    done_id_q, done_id_d;
    logic [CNT_W:0]     hit_q, hit_d;

    logic [ID_W-1:0]    pick;
    logic [FRAME_W-1:0] win_frame;
    logic               sample;

`ifdef MOORE_SCHED_FIRST_HIT_EN
    logic [CNT_W:0]     smp_q, smp_d;
    logic               found_q, found_d;
    logic [CNT_W:0]     pos_q, pos_d;
    logic               fh_valid_q, fh_valid_d;
    logic [CNT_W:0]     fh_pos_q, fh_pos_d;
`endif

    // Scan from the highest offset down so the nearest requester wins.
    always_comb begin
        int idx;
        idx  = 0;
        pick = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(last_q) + k) % NUM_REQ;
            if (bus.req[idx]) pick = ID_W'(idx);
        end
    end

    assign win_frame = bus.frame_data[int'(win_q)*FRAME_W +: FRAME_W];

    assign sample = (state_q == S_DRAIN) ||
                    ((state_q == S_SHIFT) && (step_q != '0));

    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        last_d    = last_q;
        sr_d      = sr_q;
        step_d    = step_q;
        cnt_d     = cnt_q;
        grant_d   = '0;
        fsm_in_d  = 1'b0;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        hit_d     = hit_q;
`ifdef MOORE_SCHED_FIRST_HIT_EN
        smp_d      = smp_q;
        found_d    = found_q;
        pos_d      = pos_q;
        fh_valid_d = fh_valid_q;
        fh_pos_d   = fh_pos_q;
`endif

        if (sample) begin
            if (fsm_out && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
`ifdef MOORE_SCHED_FIRST_HIT_EN
            smp_d = smp_q + 1'b1;
            if (fsm_out && !found_q) begin
                found_d = 1'b1;
                pos_d   = smp_q;
            end
`endif
        end

        unique case (state_q)
            S_IDLE: begin
                if (|bus.req) begin
                    state_d       = S_LOAD;
                    win_d         = pick;
                    grant_d[pick] = 1'b1;
                end
            end
            S_LOAD: begin
                state_d  = S_SHIFT;
                last_d   = win_q;
                sr_d     = win_frame << 1;
                fsm_in_d = win_frame[FRAME_W-1];
                step_d   = '0;
                cnt_d    = '0;
`ifdef MOORE_SCHED_FIRST_HIT_EN
                smp_d   = '0;
                found_d = 1'b0;
                pos_d   = '0;
`endif
            end
            S_SHIFT: begin
                if (step_q == SHIFT_LAST) begin
                    state_d = S_DRAIN;
                    step_d  = '0;
                end else begin
                    fsm_in_d = sr_q[FRAME_W-1];
                    sr_d     = sr_q << 1;
                    step_d   = step_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (step_q == DRAIN_LAST) begin
                    state_d   = S_REPORT;
                    done_d    = 1'b1;
                    done_id_d = win_q;
                    hit_d     = cnt_d;
`ifdef MOORE_SCHED_FIRST_HIT_EN
                    fh_valid_d = found_d;
                    fh_pos_d   = pos_d;
`endif
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            S_REPORT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        busy_d       = (state_d != S_IDLE);
        fsm_resetn_d = (state_d == S_SHIFT) || (state_d == S_DRAIN);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            win_q        <= '0;
            last_q       <= LAST_RST;
            sr_q         <= '0;
            step_q       <= '0;
            cnt_q        <= '0;
            grant_q      <= '0;
            busy_q       <= 1'b0;
            fsm_resetn_q <= 1'b0;
            fsm_in_q     <= 1'b0;
            done_q       <= 1'b0;
            done_id_q    <= '0;
            hit_q        <= '0;
`ifdef MOORE_SCHED_FIRST_HIT_EN
            smp_q      <= '0;
            found_q    <= 1'b0;
            pos_q      <= '0;
            fh_valid_q <= 1'b0;
            fh_pos_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            win_q        <= win_d;
            last_q       <= last_d;
            sr_q         <= sr_d;
            step_q       <= step_d;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            busy_q       <= busy_d;
            fsm_resetn_q <= fsm_resetn_d;
            fsm_in_q     <= fsm_in_d;
            done_q       <= done_d;
            done_id_q    <= done_id_d;
            hit_q        <= hit_d;
`ifdef MOORE_SCHED_FIRST_HIT_EN
            smp_q      <= smp_d;
            found_q    <= found_d;
            pos_q      <= pos_d;
            fh_valid_q <= fh_valid_d;
            fh_pos_q   <= fh_pos_d;
`endif
        end
    end

    assign bus.grant     = grant_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.done_id   = done_id_q;
    assign bus.hit_count = hit_q;
    assign fsm_resetn    = fsm_resetn_q;
    assign fsm_in        = fsm_in_q;
`ifdef MOORE_SCHED_FIRST_HIT_EN
    assign bus.first_hit_valid = fh_valid_q;
    assign bus.first_hit_pos   = fh_pos_q;
`endif
endmodule

// File: tb/tb_moore_seq_scheduler.sv
// Directed bench for moore_seq_scheduler with a one-flop detector stub.
// Checks first-hit outputs too when MOORE_SCHED_FIRST_HIT_EN is defined.
module tb_moore_seq_scheduler;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic fsm_resetn, fsm_in, fsm_out;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   done_cnt = 0;

    always #5 clk = ~clk;

    moore_seq_scheduler_if #(.NUM_REQ(4), .FRAME_W(8), .FLUSH_CYCLES(1)) bus();

    moore_seq_scheduler #(.NUM_REQ(4), .FRAME_W(8), .FLUSH_CYCLES(1)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .bus        (bus),
        .fsm_resetn (fsm_resetn),
        .fsm_in     (fsm_in),
        .fsm_out    (fsm_out)
    );

    always_ff @(posedge clk or negedge fsm_resetn) begin
        if (!fsm_resetn) fsm_out <= 1'b0;
        else             fsm_out <= fsm_in;
    end

    always @(posedge clk) if (bus.done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    // Expects IDLE at entry with the requester's req already high.
    task automatic serve(input int id, input logic [7:0] frm, input int hits,
                         input logic drop, input logic [3:0] late);
        @(posedge clk); #1;
        check("grant", 32'(bus.grant), 32'(1 << id));
        check("busy_load", 32'(bus.busy), 32'd1);
        check("rstn_load", 32'(fsm_resetn), 32'd0);
        if (drop) bus.req[id] = 1'b0;
        for (int b = 7; b >= 0; b--) begin
            @(posedge clk); #1;
            check("fsm_in", 32'(fsm_in), 32'(frm[b]));
            check("rstn_shift", 32'(fsm_resetn), 32'd1);
            check("grant_shift", 32'(bus.grant), 32'd0);
            if (b == 5) bus.req = bus.req | late;
        end
        @(posedge clk); #1;
        check("drain_in", 32'(fsm_in), 32'd0);
        check("done_early", 32'(bus.done), 32'd0);
        @(posedge clk); #1;
        check("done", 32'(bus.done), 32'd1);
        check("done_id", 32'(bus.done_id), 32'(id));
        check("hit_count", 32'(bus.hit_count), 32'(hits));
        check("rstn_report", 32'(fsm_resetn), 32'd0);
`ifdef MOORE_SCHED_FIRST_HIT_EN
        begin
            int pos;
            pos = -1;
            for (int b = 7; b >= 0; b--)
                if (frm[b] && pos < 0) pos = 7 - b;
            check("fh_valid", 32'(bus.first_hit_valid), 32'(pos >= 0));
            if (pos >= 0) check("fh_pos", 32'(bus.first_hit_pos), 32'(pos));
        end
`endif
        @(posedge clk); #1;
        check("done_pulse", 32'(bus.done), 32'd0);
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("done_id_hold", 32'(bus.done_id), 32'(id));
    endtask

    initial begin
        int d0;
        bus.req        = '0;
        bus.frame_data = {8'h10, 8'hFF, 8'h00, 8'hA5};
        repeat (2) @(posedge clk);
        #1;
        check("rst_grant", 32'(bus.grant), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_fsm_rstn", 32'(fsm_resetn), 32'd0);
        check("rst_fsm_in", 32'(fsm_in), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_done_id", 32'(bus.done_id), 32'd0);
        check("rst_hits", 32'(bus.hit_count), 32'd0);
`ifdef MOORE_SCHED_FIRST_HIT_EN
        check("rst_fh_valid", 32'(bus.first_hit_valid), 32'd0);
        check("rst_fh_pos", 32'(bus.first_hit_pos), 32'd0);
`endif
        resetn = 1'b1;

        // Single frame A5 from requester 0
        bus.req = 4'b0001;
        serve(0, 8'hA5, 4, 1'b1, 4'b0000);

        // Round-robin with all requests held
        do_reset();
        bus.req = 4'b1111;
        serve(0, 8'hA5, 4, 1'b0, 4'b0000);
        serve(1, 8'h00, 0, 1'b0, 4'b0000);
        serve(2, 8'hFF, 8, 1'b0, 4'b0000);
        serve(3, 8'h10, 1, 1'b0, 4'b0000);
        serve(0, 8'hA5, 4, 1'b0, 4'b0000);
        bus.req = '0;

        // Reset in the middle of a frame
        do_reset();
        bus.req = 4'b0001;
        @(posedge clk); #1;
        check("mid_grant", 32'(bus.grant), 32'd1);
        bus.req = '0;
        repeat (4) @(posedge clk);
        #1;
        check("mid_busy_pre", 32'(bus.busy), 32'd1);
        d0 = done_cnt;
        resetn = 1'b0;
        #1;
        check("mid_busy", 32'(bus.busy), 32'd0);
        check("mid_fsm_rstn", 32'(fsm_resetn), 32'd0);
        check("mid_fsm_in", 32'(fsm_in), 32'd0);
        check("mid_done", 32'(bus.done), 32'd0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("mid_no_done", 32'(done_cnt), 32'(d0));
        bus.req = 4'b1001;
        serve(0, 8'hA5, 4, 1'b1, 4'b0000);
        serve(3, 8'h10, 1, 1'b1, 4'b0000);

        // Late request from requester 2 during a shift
        bus.req = 4'b0001;
        serve(0, 8'hA5, 4, 1'b1, 4'b0100);
        serve(2, 8'hFF, 8, 1'b1, 4'b0000);
        check("late_req_clear", 32'(bus.req), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
